// File: rtl/alu_op_driver.sv
// Sequencing initiator for a combinational ALU slice: latches one command, runs one or two
// chained passes through the slice, and holds the registered result until it is consumed.
module alu_op_driver #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2*WIDTH-1:0] cmd_a,
    input  logic [2*WIDTH-1:0] cmd_b,
    input  logic [3:0]         cmd_select,
    input  logic               cmd_mode,
    input  logic               cmd_carry_in,
    input  logic               cmd_wide,
    output logic [WIDTH-1:0]   alu_in_a,
    output logic [WIDTH-1:0]   alu_in_b,
    output logic [3:0]         alu_select,
    output logic               alu_mode,
    output logic               alu_carry_in,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_carry_out,
    input  logic               alu_compare,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_result,
    output logic               rsp_carry,
    output logic               rsp_equal,
    output logic               busy,
    output logic [CNT_W-1:0]   ops_done
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t             state;
    state_t             state_nxt;

    logic [2*WIDTH-1:0] a_q;
    logic [2*WIDTH-1:0] b_q;
    logic [3:0]         sel_q;
    logic               mode_q;
    logic               cin_q;
    logic               wide_q;

    logic [2*WIDTH-1:0] result_q;
    logic               carry_q;
    logic               equal_q;
    logic [CNT_W-1:0]   ops_q;

    logic               accept;
    logic               retire;

    assign accept = cmd_valid && cmd_ready;
    assign retire = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LO;
            LO:      state_nxt = wide_q ? HI : DONE;
            HI:      state_nxt = DONE;
            DONE:    if (retire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ALU lines are only live during a pass; the high pass chains the low-pass carry.
    always_comb begin
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        busy         = 1'b1;
        alu_in_a     = '0;
        alu_in_b     = '0;
        alu_select   = '0;
        alu_mode     = 1'b0;
        alu_carry_in = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = rst;
                busy      = 1'b0;
            end
            LO: begin
                alu_in_a     = a_q[WIDTH-1:0];
                alu_in_b     = b_q[WIDTH-1:0];
                alu_select   = sel_q;
                alu_mode     = mode_q;
                alu_carry_in = cin_q;
            end
            HI: begin
                alu_in_a     = a_q[2*WIDTH-1:WIDTH];
                alu_in_b     = b_q[2*WIDTH-1:WIDTH];
                alu_select   = sel_q;
                alu_mode     = mode_q;
                alu_carry_in = carry_q;
            end
            DONE: begin
                rsp_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            sel_q  <= '0;
            mode_q <= 1'b0;
            cin_q  <= 1'b0;
            wide_q <= 1'b0;
        end else if (accept) begin
            a_q    <= cmd_a;
            b_q    <= cmd_b;
            sel_q  <= cmd_select;
            mode_q <= cmd_mode;
            cin_q  <= cmd_carry_in;
            wide_q <= cmd_wide;
        end
    end

    // Result registers only move during passes, so they stay frozen while DONE waits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            equal_q  <= 1'b0;
        end else if (state == LO) begin
            result_q[WIDTH-1:0] <= alu_result;
            carry_q             <= alu_carry_out;
            equal_q             <= alu_compare;
            if (!wide_q) begin
                result_q[2*WIDTH-1:WIDTH] <= '0;
            end
        end else if (state == HI) begin
            result_q[2*WIDTH-1:WIDTH] <= alu_result;
            carry_q                   <= alu_carry_out;
            equal_q                   <= equal_q && alu_compare;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ops_q <= '0;
        end else if (retire) begin
            ops_q <= ops_q + CNT_W'(1);
        end
    end

    assign rsp_result = result_q;
    assign rsp_carry  = carry_q;
    assign rsp_equal  = equal_q;
    assign ops_done   = ops_q;

endmodule

// File: tb/tb_alu_op_driver.sv
// Bench for alu_op_driver: an adder-style ALU stub plus a whole-operand arithmetic reference
// model, driven by directed and randomized commands.
module tb_alu_op_driver;

    localparam int W     = 16;
    localparam int CNT_W = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [2*W-1:0]  cmd_a;
    logic [2*W-1:0]  cmd_b;
    logic [3:0]      cmd_select;
    logic            cmd_mode;
    logic            cmd_carry_in;
    logic            cmd_wide;
    logic [W-1:0]    alu_in_a;
    logic [W-1:0]    alu_in_b;
    logic [3:0]      alu_select;
    logic            alu_mode;
    logic            alu_carry_in;
    logic [W-1:0]    alu_result;
    logic            alu_carry_out;
    logic            alu_compare;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [2*W-1:0]  rsp_result;
    logic            rsp_carry;
    logic            rsp_equal;
    logic            busy;
    logic [CNT_W-1:0] ops_done;

    int               n_cmp  = 0;
    int               n_fail = 0;
    logic [CNT_W-1:0] exp_ops = '0;

    always #5 clk = ~clk;

    alu_op_driver #(.WIDTH(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_select(cmd_select), .cmd_mode(cmd_mode),
        .cmd_carry_in(cmd_carry_in), .cmd_wide(cmd_wide),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_select(alu_select),
        .alu_mode(alu_mode), .alu_carry_in(alu_carry_in),
        .alu_result(alu_result), .alu_carry_out(alu_carry_out), .alu_compare(alu_compare),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_equal(rsp_equal), .busy(busy), .ops_done(ops_done)
    );

    // ALU stub: adder with carry-out and equality compare.
    logic [W:0] stub_sum;
    always_comb begin
        stub_sum      = {1'b0, alu_in_a} + {1'b0, alu_in_b} + {{W{1'b0}}, alu_carry_in};
        alu_result    = stub_sum[W-1:0];
        alu_carry_out = stub_sum[W];
        alu_compare   = (alu_in_a == alu_in_b);
    end

    task automatic test_reset();
        rst = 1'b0;
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_select = '0;
        cmd_mode = 1'b0; cmd_carry_in = 1'b0; cmd_wide = 1'b0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready/busy/valid=%b required 100", {cmd_ready, busy, rsp_valid});
        end
        n_cmp++;
        if (ops_done !== '0) begin
            n_fail++;
            $display("FAIL reset_ops: ops_done=%0d required 0", ops_done);
        end
        n_cmp++;
        if ({alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in} !== '0) begin
            n_fail++;
            $display("FAIL reset_alu: a=%h b=%h sel=%h mode=%b cin=%b required all 0",
                     alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in);
        end
        exp_ops = '0;
    endtask

    // Issues one command and follows it to retirement, checking every cycle along the way.
    task automatic run_op(input logic [2*W-1:0] a, input logic [2*W-1:0] b,
                          input logic [3:0] sel, input logic mode, input logic cin,
                          input logic wide, input int hold, input string name);
        logic [2*W:0]   full;
        logic [W:0]     lo;
        logic [2*W-1:0] exp_res;
        logic           exp_c;
        logic           exp_eq;
        full = {1'b0, a} + {1'b0, b} + {{(2*W){1'b0}}, cin};
        lo   = {1'b0, a[W-1:0]} + {1'b0, b[W-1:0]} + {{W{1'b0}}, cin};
        if (wide) begin
            exp_res = full[2*W-1:0];
            exp_c   = full[2*W];
            exp_eq  = (a == b);
        end else begin
            exp_res = {{W{1'b0}}, lo[W-1:0]};
            exp_c   = lo[W];
            exp_eq  = (a[W-1:0] == b[W-1:0]);
        end

        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle_ready: cmd_ready=%b required 1", name, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_select = sel;
        cmd_mode = mode; cmd_carry_in = cin; cmd_wide = wide;
        rsp_ready = (hold == 0);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_a = $urandom; cmd_b = $urandom; cmd_select = 4'($urandom);
        cmd_mode = ~mode; cmd_carry_in = ~cin; cmd_wide = ~wide;
        n_cmp++;
        if ({alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in, rsp_valid, busy, cmd_ready}
            !== {a[W-1:0], b[W-1:0], sel, mode, cin, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL %s lo_pass: a=%h b=%h sel=%h mode=%b cin=%b v/b/r=%b%b%b required a=%h b=%h sel=%h mode=%b cin=%b v/b/r=010",
                     name, alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in, rsp_valid, busy,
                     cmd_ready, a[W-1:0], b[W-1:0], sel, mode, cin);
        end
        if (wide) begin
            @(negedge clk);
            n_cmp++;
            if ({alu_in_a, alu_in_b, alu_select, alu_carry_in, rsp_valid}
                !== {a[2*W-1:W], b[2*W-1:W], sel, lo[W], 1'b0}) begin
                n_fail++;
                $display("FAIL %s hi_pass: a=%h b=%h sel=%h cin=%b valid=%b required a=%h b=%h sel=%h cin=%b valid=0",
                         name, alu_in_a, alu_in_b, alu_select, alu_carry_in, rsp_valid,
                         a[2*W-1:W], b[2*W-1:W], sel, lo[W]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, rsp_result, rsp_carry, rsp_equal} !== {1'b1, exp_res, exp_c, exp_eq}) begin
            n_fail++;
            $display("FAIL %s response: valid=%b result=%h carry=%b equal=%b required valid=1 result=%h carry=%b equal=%b",
                     name, rsp_valid, rsp_result, rsp_carry, rsp_equal, exp_res, exp_c, exp_eq);
        end
        n_cmp++;
        if ({alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in} !== '0) begin
            n_fail++;
            $display("FAIL %s done_alu_idle: a=%h b=%h sel=%h required 0", name, alu_in_a, alu_in_b, alu_select);
        end
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            @(negedge clk);
            n_cmp++;
            if ({rsp_valid, rsp_result, rsp_carry, rsp_equal, cmd_ready, ops_done}
                !== {1'b1, exp_res, exp_c, exp_eq, 1'b0, exp_ops}) begin
                n_fail++;
                $display("FAIL %s hold%0d: valid=%b result=%h carry=%b equal=%b ready=%b ops=%0d required 1 %h %b %b 0 %0d",
                         name, i, rsp_valid, rsp_result, rsp_carry, rsp_equal, cmd_ready, ops_done,
                         exp_res, exp_c, exp_eq, exp_ops);
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        exp_ops = exp_ops + 16'd1;
        n_cmp++;
        if ({rsp_valid, busy, cmd_ready, ops_done} !== {3'b001, exp_ops}) begin
            n_fail++;
            $display("FAIL %s retire: valid/busy/ready=%b%b%b ops=%0d required 001 ops=%0d",
                     name, rsp_valid, busy, cmd_ready, ops_done, exp_ops);
        end
    endtask

    task automatic test_narrow();
        run_op(32'h0000_1234, 32'h0000_0001, 4'h9, 1'b0, 1'b0, 1'b0, 0, "narrow");
        run_op(32'hABCD_FFFF, 32'h5555_0000, 4'h3, 1'b1, 1'b1, 1'b0, 0, "narrow_carry");
    endtask

    task automatic test_wide_chain();
        run_op(32'h0000_FFFF, 32'h0000_0001, 4'h9, 1'b0, 1'b0, 1'b1, 0, "wide_chain");
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 4'h9, 1'b0, 1'b0, 1'b1, 0, "wide_wrap");
    endtask

    task automatic test_backpressure();
        run_op(32'h8765_4321, 32'h1111_2222, 4'h6, 1'b0, 1'b1, 1'b1, 5, "backpressure");
    endtask

    task automatic test_compare();
        run_op(32'h1234_5678, 32'h1234_5678, 4'h6, 1'b0, 1'b0, 1'b1, 0, "cmp_equal");
        run_op(32'h1234_5678, 32'h1235_5678, 4'h6, 1'b0, 1'b0, 1'b1, 0, "cmp_hi_diff");
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_a = 32'hFFFF_FFFF; cmd_b = 32'h0000_0001;
        cmd_select = 4'h9; cmd_mode = 1'b0; cmd_carry_in = 1'b0; cmd_wide = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (alu_in_a !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL midrst_in_hi: alu_in_a=%h required ffff", alu_in_a);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in, rsp_valid, rsp_result,
             rsp_carry, rsp_equal, busy, cmd_ready, ops_done} !== '0) begin
            n_fail++;
            $display("FAIL midrst_async: a=%h b=%h cin=%b valid=%b result=%h busy=%b ready=%b ops=%0d required all 0",
                     alu_in_a, alu_in_b, alu_carry_in, rsp_valid, rsp_result, busy, cmd_ready, ops_done);
        end
        exp_ops = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_valid%0d: rsp_valid=%b required 0", i, rsp_valid);
            end
        end
        rst = 1'b1;
        run_op(32'h0F0F_8000, 32'h00F0_8000, 4'h9, 1'b0, 1'b1, 1'b1, 0, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [2*W-1:0] a;
            logic [2*W-1:0] b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
            run_op(a, b, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_narrow();
        test_wide_chain();
        test_backpressure();
        test_compare();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
